// File: rtl/mcp3201_slave_emu_if.sv
// MCP3201 SPI pin bundle between the ADC driver (master) and the
// ADC emulator (slave).
// Ports: spi_clk, spi_ncs from master; spi_dout, spi_dout_oe from slave.
interface mcp3201_slave_emu_if;
   logic spi_clk;
   logic spi_ncs;
   logic spi_dout;
   logic spi_dout_oe;

   modport master (
      output spi_clk,
      output spi_ncs,
      input  spi_dout,
      input  spi_dout_oe
   );

   modport slave (
      input  spi_clk,
      input  spi_ncs,
      output spi_dout,
      output spi_dout_oe
   );
endinterface

// File: rtl/mcp3201_slave_emu.sv
// MCP3201 12-bit ADC responder: oversamples the master's spi_clk/spi_ncs
// on sys_clk and shifts a null bit then hold[11:0] MSB-first.
// Ports: sys_clk, sys_rst_n (async, active low); spi (slave modport:
// spi_clk, spi_ncs in; spi_dout, spi_dout_oe out); sample_data[11:0],
// sample_valid in; busy, frame_done, frame_abort out.
// Option: define MCP3201_LSB_FIRST_EN for the B1..B11 LSB-first tail.
module mcp3201_slave_emu #(
   parameter int SYNC_STAGES = 2
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   mcp3201_slave_emu_if.slave spi,
   input  logic [11:0]        sample_data,
   input  logic               sample_valid,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_abort
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_NULL,
      S_MSB,
`ifdef MCP3201_LSB_FIRST_EN
      S_LSB,
`endif
      S_TRAIL
   } state_t;

   // synchronizers; reset to the bus idle levels so a
   // deselected bus never looks like an edge
   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] ncs_sync;
   logic                   clk_prev;
   logic                   ncs_prev;
   logic                   clk_s;
   logic                   ncs_s;
   logic                   clk_fall;
   logic                   ncs_fall;
   logic                   ncs_rise;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign ncs_s = ncs_sync[SYNC_STAGES-1];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clk_sync <= '0;
         ncs_sync <= '1;
         clk_prev <= 1'b0;
         ncs_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0],
                      spi.spi_clk};
         ncs_sync <= {ncs_sync[SYNC_STAGES-2:0],
                      spi.spi_ncs};
         clk_prev <= clk_s;
         ncs_prev <= ncs_s;
      end
   end

   assign clk_fall = clk_prev & ~clk_s;
   assign ncs_fall = ncs_prev & ~ncs_s;
   assign ncs_rise = ~ncs_prev & ncs_s;

   // holding register: latest sample_valid wins,
   // even while a frame is being shifted
   logic [11:0] hold;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold <= '0;
      end else if (sample_valid) begin
         hold <= sample_data;
      end
   end

   state_t      state;
   state_t      state_n;
   logic [11:0] sreg;
   logic [11:0] sreg_n;
   logic [4:0]  fe_cnt;
   logic [4:0]  fe_n;
   logic        dout_q;
   logic        dout_n;
   logic        oe_q;
   logic        oe_n;
   logic        done_q;
   logic        done_n;
   logic        abort_q;
   logic        abort_n;
   logic [3:0]  bit_idx;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state   <= S_IDLE;
         sreg    <= '0;
         fe_cnt  <= '0;
         dout_q  <= 1'b0;
         oe_q    <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_n;
         sreg    <= sreg_n;
         fe_cnt  <= fe_n;
         dout_q  <= dout_n;
         oe_q    <= oe_n;
         done_q  <= done_n;
         abort_q <= abort_n;
      end
   end

   // fe_cnt holds the number of falling edges seen
   // before the current one, so edge k sees k-1.
   always_comb begin
      state_n = state;
      sreg_n  = sreg;
      fe_n    = fe_cnt;
      dout_n  = dout_q;
      oe_n    = oe_q;
      done_n  = 1'b0;
      abort_n = 1'b0;
      bit_idx = 4'd0;

      if (state != S_IDLE && clk_fall &&
          fe_cnt != 5'd31) begin
         fe_n = fe_cnt + 5'd1;
      end

      unique case (state)
         S_IDLE: begin
            oe_n   = 1'b0;
            dout_n = 1'b0;
            if (ncs_fall) begin
               state_n = S_SAMPLE;
               fe_n    = '0;
            end
         end
         S_SAMPLE: begin
            oe_n = 1'b0;
            if (clk_fall) begin
               state_n = S_NULL;
            end
         end
         S_NULL: begin
            if (clk_fall) begin
               sreg_n  = hold;
               oe_n    = 1'b1;
               dout_n  = 1'b0;
               state_n = S_MSB;
            end
         end
         S_MSB: begin
            if (clk_fall) begin
               // edges 3..14 -> B11..B0
               bit_idx = 4'(5'd13 - fe_cnt);
               dout_n  = sreg[bit_idx];
               if (fe_cnt == 5'd13) begin
`ifdef MCP3201_LSB_FIRST_EN
                  state_n = S_LSB;
`else
                  state_n = S_TRAIL;
`endif
               end
            end
         end
`ifdef MCP3201_LSB_FIRST_EN
         S_LSB: begin
            if (clk_fall) begin
               // edges 15..25 -> B1..B11
               bit_idx = 4'(fe_cnt - 5'd13);
               dout_n  = sreg[bit_idx];
               if (fe_cnt == 5'd24) begin
                  state_n = S_TRAIL;
               end
            end
         end
`endif
         S_TRAIL: begin
            if (clk_fall) begin
               dout_n = 1'b0;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // deselect wins over any same-cycle clock edge
      if (state != S_IDLE && ncs_rise) begin
         state_n = S_IDLE;
         oe_n    = 1'b0;
         dout_n  = 1'b0;
         if (fe_cnt >= 5'd14) begin
            done_n = 1'b1;
         end else begin
            abort_n = 1'b1;
         end
      end
   end

   assign spi.spi_dout    = dout_q;
   assign spi.spi_dout_oe = oe_q;
   assign busy            = (state != S_IDLE);
   assign frame_done      = done_q;
   assign frame_abort     = abort_q;

endmodule
